// File: rtl/nand_gate_3in_if.sv
// nand_gate_3in_if
//   Bundles the operand inputs and all observable outputs of nand_gate_3in.
//   master : the side that drives a/b/c and watches the outputs.
//   slave  : the gate itself; it reads a/b/c and drives every output.
//   Parameters
//     WIDTH : number of independent NAND lanes.
//     CNT_W : width of the low-output cycle counter.
interface nand_gate_3in_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;
   logic [7:0]       combo_seen;
   logic             all_seen;
   logic [CNT_W-1:0] low_count;

   modport master (
      output a, b, c,
      input  out, out_q, combo_seen, all_seen, low_count
   );

   modport slave (
      input  a, b, c,
      output out, out_q, combo_seen, all_seen, low_count
   );
endinterface

// File: rtl/nand_gate_3in.sv
// nand_gate_3in
//   Per-lane 3-input NAND with a zero-latency output, a registered copy of
//   that output, and a small activity monitor on lane 0.
//   Ports
//     clk             : single clock, all state changes on the rising edge.
//     rst             : synchronous, active-high reset; wins over all updates.
//     bus.a/b/c       : operands, WIDTH lanes each.
//     bus.out         : ~(a & b & c) per lane, purely combinational.
//     bus.out_q       : bus.out registered one cycle (all ones in reset).
//     bus.combo_seen  : sticky bitmap of lane-0 {a,b,c} combinations seen.
//     bus.all_seen    : every one of the eight combinations has been seen.
//     bus.low_count   : edges at which out[0] was 0, saturating.
module nand_gate_3in #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   nand_gate_3in_if.slave     bus
);

   logic [WIDTH-1:0] nand_out;
   logic [WIDTH-1:0] out_q_r;
   logic [7:0]       seen_r;
   logic [CNT_W-1:0] low_cnt_r;
   logic [2:0]       combo_idx;
   logic             cnt_full;

   // Output path does not touch clk or rst.
   assign nand_out  = ~(bus.a & bus.b & bus.c);

   // a[0] is the MSB of the monitor index.
   assign combo_idx = {bus.a[0], bus.b[0], bus.c[0]};
   assign cnt_full  = &low_cnt_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q_r   <= '1;
         seen_r    <= 8'h00;
         low_cnt_r <= '0;
      end else begin
         out_q_r <= nand_out;
         seen_r  <= seen_r | (8'h01 << combo_idx);
         // Counter sticks at its maximum rather than wrapping.
         if (!nand_out[0] && !cnt_full) begin
            low_cnt_r <= low_cnt_r + 1'b1;
         end
      end
   end

   assign bus.out        = nand_out;
   assign bus.out_q      = out_q_r;
   assign bus.combo_seen = seen_r;
   assign bus.all_seen   = &seen_r;
   assign bus.low_count  = low_cnt_r;

endmodule

// File: tb/tb_nand_gate_3in.sv
// Bench for nand_gate_3in: a 4-lane, 8-bit-counter instance and a 1-lane,
// 2-bit-counter instance share clock and reset; lane 0 of both sees the same
// operands. A behavioural model tracks the expected outputs.
module tb_nand_gate_3in;

   logic clk;
   logic rst;

   nand_gate_3in_if #(.WIDTH(4), .CNT_W(8)) bus0 ();
   nand_gate_3in_if #(.WIDTH(1), .CNT_W(2)) bus1 ();

   nand_gate_3in #(.WIDTH(4), .CNT_W(8)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   nand_gate_3in #(.WIDTH(1), .CNT_W(2)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_chk;
   int n_fail;

   // reference model state
   logic [3:0] outq_m;
   logic [7:0] seen_m;
   int         low8_m;
   int         low2_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A lane is low only when all three of its inputs are 1.
   function automatic logic [3:0] nand_model(input logic [3:0] av, bv, cv);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i] = ((int'(av[i]) + int'(bv[i]) + int'(cv[i])) == 3) ? 1'b0 : 1'b1;
      end
      return r;
   endfunction

   task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] cv,
                       input logic r);
      logic [3:0] exp_out;
      int         idx;
      @(negedge clk);
      bus0.a = av;
      bus0.b = bv;
      bus0.c = cv;
      bus1.a = av[0:0];
      bus1.b = bv[0:0];
      bus1.c = cv[0:0];
      rst    = r;
      n_vec++;
      exp_out = nand_model(av, bv, cv);
      #1;
      check("out0", 32'(bus0.out), 32'(exp_out));
      check("out1", 32'(bus1.out), 32'(exp_out[0]));
      @(posedge clk);
      if (r) begin
         outq_m = 4'hF;
         seen_m = 8'h00;
         low8_m = 0;
         low2_m = 0;
      end else begin
         outq_m = exp_out;
         idx = 4 * int'(av[0]) + 2 * int'(bv[0]) + int'(cv[0]);
         seen_m[idx] = 1'b1;
         if (exp_out[0] == 1'b0) begin
            low8_m = (low8_m + 1 > 255) ? 255 : low8_m + 1;
            low2_m = (low2_m + 1 > 3) ? 3 : low2_m + 1;
         end
      end
      #1;
      check("out_q0",      32'(bus0.out_q),      32'(outq_m));
      check("combo_seen0", 32'(bus0.combo_seen), 32'(seen_m));
      check("all_seen0",   32'(bus0.all_seen),   (seen_m == 8'hFF) ? 32'd1 : 32'd0);
      check("low_count0",  32'(bus0.low_count),  32'(low8_m));
      check("out_q1",      32'(bus1.out_q),      32'(outq_m[0]));
      check("combo_seen1", 32'(bus1.combo_seen), 32'(seen_m));
      check("low_count1",  32'(bus1.low_count),  32'(low2_m));
   endtask

   initial begin
      int sat_exp [6];
      logic [3:0] ra, rb, rc;
      sat_exp = '{1, 2, 3, 3, 3, 3};
      n_vec = 0;
      n_chk = 0;
      n_fail = 0;
      outq_m = 4'hF;
      seen_m = 8'h00;
      low8_m = 0;
      low2_m = 0;
      rst = 1'b1;
      bus0.a = '0; bus0.b = '0; bus0.c = '0;
      bus1.a = '0; bus1.b = '0; bus1.c = '0;

      // reset state
      step(4'h0, 4'h0, 4'h0, 1'b1);
      check("rst_out_q", 32'(bus0.out_q), 32'hF);
      check("rst_all_seen", 32'(bus0.all_seen), 32'd0);

      // clocked truth-table sweep on lane 0, upper lanes random
      for (int v = 0; v < 8; v++) begin
         ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
         ra[0] = v[2]; rb[0] = v[1]; rc[0] = v[0];
         step(ra, rb, rc, 1'b0);
      end
      check("sweep_combo", 32'(bus0.combo_seen), 32'hFF);
      check("sweep_all_seen", 32'(bus0.all_seen), 32'd1);
      check("sweep_low", 32'(bus0.low_count), 32'd1);

      // reset in the middle of a sweep
      step(4'h0, 4'h0, 4'h0, 1'b1);
      for (int v = 0; v < 4; v++) begin
         step({3'b000, v[2]}, {3'b000, v[1]}, {3'b000, v[0]}, 1'b0);
      end
      step(4'h1, 4'h0, 4'h0, 1'b1);
      check("mid_rst_combo", 32'(bus0.combo_seen), 32'h00);
      check("mid_rst_low", 32'(bus0.low_count), 32'd0);
      check("mid_rst_out_q", 32'(bus1.out_q), 32'd1);
      for (int v = 4; v < 8; v++) begin
         step({3'b000, v[2]}, {3'b000, v[1]}, {3'b000, v[0]}, 1'b0);
      end

      // saturation of the 2-bit counter
      step(4'h0, 4'h0, 4'h0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         step(4'hF, 4'hF, 4'hF, 1'b0);
         check("sat_low2", 32'(bus1.low_count), 32'(sat_exp[k]));
         check("sat_out1", 32'(bus1.out), 32'd0);
      end

      // independent lanes
      step(4'h0, 4'h0, 4'h0, 1'b1);
      step(4'b1111, 4'b1010, 4'b1100, 1'b0);
      check("lanes_out", 32'(bus0.out), 32'h7);
      check("lanes_out_q", 32'(bus0.out_q), 32'h7);
      check("lanes_combo", 32'(bus0.combo_seen), 32'h10);

      // random traffic with occasional reset
      for (int k = 0; k < 300; k++) begin
         ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
         // bias toward all-ones lanes so the counters see real activity
         if ($urandom_range(0, 3) == 0) begin
            ra = 4'hF; rb = 4'hF; rc = 4'hF;
         end
         step(ra, rb, rc, ($urandom_range(0, 39) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
